pe_typeb_scheduler: RTL and testbench

//  Shares one PE_typeB datapath (int64->double convert or passthrough) between NREQ requesters.

---
 rtl/pe_pkg.sv | 26 ++
 rtl/pe_tag_pipe.sv | 30 +++
 rtl/pe_typeb_scheduler.sv | 161 ++++++++++++++++
 tb/tb_pe_typeb_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types for the PE_typeB scheduler.
// Holds op/tag encodings and FSM states.
package pe_pkg;

   localparam int DWIDTH_DOUBLE = 64;
   localparam int NREQ_MAX      = 4;
   localparam int ID_W          = $clog2(NREQ_MAX);

   typedef enum logic [1:0] {
      OP_PASS = 2'b00,
      OP_CVT  = 2'b01
   } pe_op_e;

   typedef struct packed {
      logic            v;
      logic [ID_W-1:0] id;
      pe_op_e          op;
   } pe_tag_t;

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_DRAINED
   } sched_state_e;

endpackage

// File: rtl/pe_tag_pipe.sv
// Tag shift pipe that travels alongside the PE datapath.
// Clearing it on reset masks stale PE contents.
module pe_tag_pipe
   import pe_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic    clk,
   input  logic    rst,
   input  pe_tag_t i_tag,
   output pe_tag_t o_tail
);

   pe_tag_t [DEPTH-1:0] r_pipe;

   // Shift a new tag in every cycle; invalid tags are all-zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_tail = r_pipe[DEPTH-1];

endmodule

// File: rtl/pe_typeb_scheduler.sv
// Round-robin sharing of one PE_typeB among NREQ requesters.
// Tags each issue and routes results back to the owner.
module pe_typeb_scheduler
   import pe_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DW      = DWIDTH_DOUBLE,
   parameter int LATENCY = 4,
   localparam int CW     = $clog2(LATENCY+2),
   localparam int RW     = $clog2(NREQ)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic [NREQ*2-1:0]  req_op,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [DW-1:0]      rsp_data,
   output logic [DW-1:0]      pe_inp1,
   output logic [1:0]         pe_op,
   input  logic [DW-1:0]      pe_out1,
   input  logic               drain_req,
   output logic               drained,
   output logic [CW-1:0]      inflight
);

   sched_state_e    r_state;
   sched_state_e    w_state_nxt;
   logic [RW-1:0]   r_rr;
   logic [RW-1:0]   w_win;
   logic            w_any;
   logic [NREQ-1:0] w_grant;
   logic            w_acc;
   logic [DW-1:0]   w_sel_data;
   pe_op_e          w_sel_op;
   pe_tag_t         w_tag_in;
   pe_tag_t         w_tail;
   pe_tag_t         r_out_tag;
   logic [CW-1:0]   r_inflight;
   logic [NREQ-1:0] w_op_hi;
   logic            w_op_unused;

   // Find the first valid requester at or after the rr pointer.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_any && req_valid[(int'(r_rr) + k) % NREQ]) begin
            w_any = 1'b1;
            w_win = RW'((int'(r_rr) + k) % NREQ);
         end
      end
   end

   // Op bit1 carries no meaning for this PE.
   always_comb begin
      w_op_hi = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_op_hi[k] = req_op[k*2+1];
      end
   end
   assign w_op_unused = ^w_op_hi;

   assign w_grant = (!rst && r_state == S_RUN && !drain_req && w_any)
                    ? (NREQ'(1) << w_win) : '0;
   assign w_acc      = |(w_grant & req_valid);
   assign w_sel_data = req_data[w_win*DW +: DW];
   assign w_sel_op   = req_op[w_win*2] ? OP_CVT : OP_PASS;
   assign req_ready  = w_grant;

   // Build the issue tag; idle cycles push an all-zero tag.
   always_comb begin
      w_tag_in = '0;
      if (w_acc) begin
         w_tag_in.v  = 1'b1;
         w_tag_in.id = ID_W'(w_win);
         w_tag_in.op = w_sel_op;
      end
   end

   pe_tag_pipe #(
      .DEPTH (LATENCY)
   ) u_tag_pipe (
      .clk    (clk),
      .rst    (rst),
      .i_tag  (w_tag_in),
      .o_tail (w_tail)
   );

   // Issue register, rr pointer and output-stage tag alignment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pe_inp1   <= '0;
         r_rr      <= '0;
         r_out_tag <= '0;
      end else begin
         pe_inp1   <= w_acc ? w_sel_data : '0;
         r_out_tag <= w_tail;
         if (w_acc) begin
            r_rr <= (int'(w_win) == NREQ-1) ? '0 : w_win + RW'(1);
         end
      end
   end

   assign pe_op = r_out_tag.v ? r_out_tag.op : OP_PASS;

   // Return the PE result to the owner of the output-stage tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else if (r_out_tag.v) begin
         rsp_valid <= NREQ'(1) << r_out_tag.id;
         rsp_data  <= pe_out1;
      end else begin
         rsp_valid <= '0;
      end
   end

   // Count issues not yet answered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight <= '0;
      end else begin
         r_inflight <= r_inflight + CW'(w_acc) - CW'(r_out_tag.v);
      end
   end

   assign inflight = r_inflight;

   // Drain FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Drain FSM next state and status.
   always_comb begin
      w_state_nxt = r_state;
      drained     = 1'b0;
      unique case (r_state)
         S_RUN: begin
            if (drain_req) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (!drain_req)           w_state_nxt = S_RUN;
            else if (r_inflight == 0) w_state_nxt = S_DRAINED;
         end
         S_DRAINED: begin
            drained = 1'b1;
            if (!drain_req) w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

endmodule

// File: tb/tb_pe_typeb_scheduler.sv
// Self-checking bench for pe_typeb_scheduler.
// Scoreboard model of arbitration, drain and responses.
module tb_pe_typeb_scheduler;

   localparam int NREQ = 4;
   localparam int DW   = 64;
   localparam int LAT  = 4;
   localparam int CW   = $clog2(LAT+2);

   logic               clk;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ*2-1:0]  req_op;
   logic [NREQ-1:0]    rsp_valid;
   logic [DW-1:0]      rsp_data;
   logic [DW-1:0]      pe_inp1;
   logic [1:0]         pe_op;
   logic [DW-1:0]      pe_out1;
   logic               drain_req;
   logic               drained;
   logic [CW-1:0]      inflight;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   pe_typeb_scheduler #(
      .NREQ    (NREQ),
      .DW      (DW),
      .LATENCY (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .pe_inp1   (pe_inp1),
      .pe_op     (pe_op),
      .pe_out1   (pe_out1),
      .drain_req (drain_req),
      .drained   (drained),
      .inflight  (inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] cvt(input logic [63:0] x);
      real r;
      r = real'($signed(x));
      return $realtobits(r);
   endfunction

   // Stand-in PE_typeB: LAT-stage convert and passthrough lanes,
   // output selected by the op aligned with the output stage.
   logic [63:0] pe_p [LAT];
   logic [63:0] pe_c [LAT];
   always @(posedge clk) begin
      pe_p[0] <= pe_inp1;
      pe_c[0] <= cvt(pe_inp1);
      for (int i = 1; i < LAT; i++) begin
         pe_p[i] <= pe_p[i-1];
         pe_c[i] <= pe_c[i-1];
      end
   end
   assign pe_out1 = pe_op[0] ? pe_c[LAT-1] : pe_p[LAT-1];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Scoreboard: expected responses, ordered by due cycle.
   typedef struct {
      int          due;
      int          id;
      logic [63:0] data;
      logic [1:0]  op;
   } exp_t;

   exp_t q[$];
   int   m_rr   = 0;
   int   m_mode = 0;

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      exp_t        e;
      logic        ev;
      logic [3:0]  g;
      logic [1:0]  eop;
      int          w;
      int          infl;
      if (rst) begin
         chk("rst_req_ready", 64'(req_ready), 64'd0);
         chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("rst_rsp_data", rsp_data, 64'd0);
         chk("rst_pe_inp1", pe_inp1, 64'd0);
         chk("rst_pe_op", 64'(pe_op), 64'd0);
         chk("rst_drained", 64'(drained), 64'd0);
         chk("rst_inflight", 64'(inflight), 64'd0);
         q.delete();
         m_rr   = 0;
         m_mode = 0;
      end else begin
         ev = 1'b0;
         if (q.size() > 0 && q[0].due == cyc) begin
            e  = q.pop_front();
            ev = 1'b1;
         end
         chk("rsp_valid", 64'(rsp_valid),
             ev ? 64'(4'b1 << e.id) : 64'd0);
         if (ev) chk("rsp_data", rsp_data, e.data);
         infl = q.size();
         chk("inflight", 64'(inflight), 64'(infl));
         eop = 2'b00;
         if (q.size() > 0 && q[0].due == cyc + 1) eop = q[0].op;
         chk("pe_op", 64'(pe_op), 64'(eop));
         chk("drained", 64'(drained), 64'(m_mode == 2));
         g = '0;
         w = -1;
         if (m_mode == 0 && !drain_req) begin
            for (int k = 0; k < NREQ; k++) begin
               if (w < 0 && req_valid[(m_rr + k) % NREQ])
                  w = (m_rr + k) % NREQ;
            end
            if (w >= 0) g = 4'b1 << w;
         end
         chk("req_ready", 64'(req_ready), 64'(g));
         if (w >= 0) begin
            e.due  = cyc + LAT + 2;
            e.id   = w;
            e.op   = {1'b0, req_op[w*2]};
            e.data = req_op[w*2] ? cvt(req_data[w*DW +: DW])
                                 : req_data[w*DW +: DW];
            q.push_back(e);
            m_rr = (w + 1) % NREQ;
         end
         case (m_mode)
            0: if (drain_req) m_mode = 1;
            1: if (!drain_req) m_mode = 0;
               else if (infl == 0) m_mode = 2;
            default: if (!drain_req) m_mode = 0;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = '0;
      req_op    = '0;
      req_data  = '0;
   endtask

   task automatic rnd_data();
      for (int i = 0; i < NREQ; i++)
         req_data[i*DW +: DW] = {$urandom, $urandom};
   endtask

   initial begin
      int c;
      bit done;
      rst       = 1'b1;
      drain_req = 1'b0;
      idle();
      step();
      step();
      step();
      rst = 1'b0;

      // T1 single convert at cycle 10
      while (cyc < 10) step();
      req_valid   = 4'b0010;
      req_data[DW +: DW] = 64'd5;
      req_op      = 8'b0000_0100;
      step();
      idle();
      while (cyc < 16) step();
      @(negedge clk);
      chk("t1_rsp_valid", 64'(rsp_valid), 64'h2);
      chk("t1_rsp_data", rsp_data, 64'h4014000000000000);

      // T2 passthrough on requester 0
      step();
      c = cyc;
      req_valid = 4'b0001;
      req_data[0 +: DW] = 64'hDEADBEEF00000001;
      step();
      idle();
      while (cyc < c + 5) step();
      @(negedge clk);
      chk("t2_pe_op", 64'(pe_op), 64'd0);
      step();
      @(negedge clk);
      chk("t2_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("t2_rsp_data", rsp_data, 64'hDEADBEEF00000001);

      // T3 round-robin from rr=0 (grant req 3 first to wrap rr)
      step();
      req_valid = 4'b1000;
      step();
      req_valid = 4'b0111;
      for (int k = 0; k < 6; k++) begin
         rnd_data();
         req_op = 8'($urandom);
         @(negedge clk);
         chk("t3_grant", 64'(req_ready), 64'(4'b1 << (k % 3)));
         step();
      end

      // T6 saturation: inflight settles at LAT+1
      req_valid = 4'b1111;
      for (int k = 0; k < 12; k++) begin
         rnd_data();
         req_op = 8'($urandom);
         step();
      end
      @(negedge clk);
      chk("t6_inflight", 64'(inflight), 64'd5);

      // T4 drain with 5 in flight
      step();
      drain_req = 1'b1;
      @(negedge clk);
      chk("t4_ready_off", 64'(req_ready), 64'd0);
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         step();
         @(negedge clk);
         if (drained) done = 1'b1;
      end
      chk("t4_drained", 64'(done), 64'd1);
      chk("t4_inflight", 64'(inflight), 64'd0);
      step();
      drain_req = 1'b0;
      @(negedge clk);
      chk("t4_still_off", 64'(req_ready), 64'd0);
      step();
      @(negedge clk);
      chk("t4_resume", 64'(req_ready != 0), 64'd1);

      // T5 reset with 3 in flight
      step();
      idle();
      step();
      req_valid = 4'b0001;
      req_data[0 +: DW] = 64'd77;
      step();
      step();
      step();
      idle();
      #2 rst = 1'b1;
      #1;
      chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("t5_inflight", 64'(inflight), 64'd0);
      chk("t5_pe_inp1", pe_inp1, 64'd0);
      step();
      step();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("t5_quiet", 64'(rsp_valid), 64'd0);
         step();
      end

      // Random traffic with occasional drains
      for (int k = 0; k < 600; k++) begin
         req_valid = 4'($urandom);
         req_op    = 8'($urandom);
         rnd_data();
         if (!drain_req && $urandom_range(0, 29) == 0) drain_req = 1'b1;
         else if (drain_req && $urandom_range(0, 9) == 0) drain_req = 1'b0;
         step();
      end
      drain_req = 1'b0;
      idle();
      repeat (10) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
